// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types used by the register-file writeback path.
package lc3b_types;
   typedef logic [15:0] lc3b_word;
   typedef logic [2:0]  lc3b_reg;
endpackage

// File: rtl/regfile_wb_queue.sv
// Writeback queue in front of the register-file write port: buffers writebacks
// while the port is stalled and forwards the youngest pending value to decode.
module regfile_wb_queue
   import lc3b_types::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     enq_valid,
   output logic                     enq_ready,
   input  lc3b_reg                  enq_dest,
   input  lc3b_word                 enq_data,
   input  logic                     wb_stall,
   output logic                     wb_load,
   output lc3b_reg                  wb_dest,
   output lc3b_word                 wb_data,
   input  lc3b_reg                  lookup_a,
   input  lc3b_reg                  lookup_b,
   output logic                     hit_a,
   output logic                     hit_b,
   output lc3b_word                 fwd_a,
   output lc3b_word                 fwd_b,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   lc3b_reg           r_dest [DEPTH];
   lc3b_word          r_data [DEPTH];
   logic [PW-1:0]     r_head;
   logic [PW-1:0]     r_tail;
   logic [CW-1:0]     r_count;

   logic              w_enq;
   logic              w_pop;
   logic              w_nonempty;

   assign w_nonempty = (r_count != '0);
   // Ready looks only at the registered count: a full queue never accepts,
   // even when the head is draining in the same cycle.
   assign enq_ready  = (r_count < CW'(DEPTH));
   assign w_enq      = enq_valid && enq_ready;
   assign wb_load    = w_nonempty && !wb_stall;
   assign w_pop      = wb_load;
   assign wb_dest    = w_nonempty ? r_dest[r_head] : '0;
   assign wb_data    = w_nonempty ? r_data[r_head] : '0;
   assign count      = r_count;

   // Walk entries oldest to youngest so the last match (youngest) wins.
   always_comb begin
      hit_a = 1'b0;
      hit_b = 1'b0;
      fwd_a = '0;
      fwd_b = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (CW'(i) < r_count) begin
            if (r_dest[r_head + PW'(i)] == lookup_a) begin
               hit_a = 1'b1;
               fwd_a = r_data[r_head + PW'(i)];
            end
            if (r_dest[r_head + PW'(i)] == lookup_b) begin
               hit_b = 1'b1;
               fwd_b = r_data[r_head + PW'(i)];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_enq) begin
            r_dest[r_tail] <= enq_dest;
            r_data[r_tail] <= enq_data;
            r_tail         <= r_tail + PW'(1);
         end
         if (w_pop) begin
            r_head <= r_head + PW'(1);
         end
         case ({w_enq, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: doc/regfile_wb_queue.md
REGFILE_WB_QUEUE -- requirements
Module: regfile_wb_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffered writeback entries (power of 2, >= 2).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port enq_valid  input  1  producer offers a register writeback.
REQ-005 SHALL have port enq_ready  output  1  queue accepts an offer this cycle.
REQ-006 SHALL have port enq_dest  input  3 (lc3b_reg)  destination register of the offer.
REQ-007 SHALL have port enq_data  input  16 (lc3b_word)  data of the offer.
REQ-008 SHALL have port wb_stall  input  1  register-file write port unavailable this cycle.
REQ-009 SHALL have port wb_load  output  1  register-file write enable.
REQ-010 SHALL have port wb_dest  output  3 (lc3b_reg)  register-file write address.
REQ-011 SHALL have port wb_data  output  16 (lc3b_word)  register-file write data.
REQ-012 SHALL have ports lookup_a, lookup_b  input  3 each (lc3b_reg)  registers being read by the decode stage.
REQ-013 SHALL have ports hit_a, hit_b  output  1 each  a pending write to the looked-up register is queued.
REQ-014 SHALL have ports fwd_a, fwd_b  output  16 each  forwarded data for lookup_a / lookup_b.
REQ-015 SHALL have port count  output  $clog2(DEPTH)+1  number of valid entries.

Function
REQ-016 SHALL store entries in order as a circular buffer; head and tail pointers wrap modulo DEPTH.
REQ-017 SHALL drive enq_ready = (count < DEPTH), independent of same-cycle drain; no pass-through when full.
REQ-018 SHALL write {enq_dest, enq_data} at tail and advance tail when enq_valid && enq_ready.
REQ-019 SHALL ignore enq_valid when enq_ready = 0, with no state change.
REQ-020 SHALL drive wb_load = (count != 0) && !wb_stall, combinationally from head entry.
REQ-021 SHALL drive wb_dest/wb_data from head entry when count != 0, and 0 when empty.
REQ-022 SHALL pop head (advance head) in every cycle wb_load = 1.
REQ-023 SHALL apply enqueue and pop in the same cycle together: count unchanged, both pointers advance.
REQ-024 SHALL give enqueue-to-wb_load latency of 1 cycle into an empty queue with wb_stall = 0.
REQ-025 SHALL hold head entry and outputs stable while wb_stall = 1.
REQ-026 SHALL set hit_x = 1 when any valid entry, head included, has dest == lookup_x.
REQ-027 SHALL drive fwd_x with the data of the youngest matching entry on a hit, and 0 on a miss.
REQ-028 SHALL not expose an entry being enqueued this cycle to lookups until the next cycle.
REQ-029 SHALL compute hit/fwd combinationally from current state; lookups have no side effects.

Reset
REQ-030 SHALL, on posedge clk with reset = 1, clear head, tail and count to 0 and discard all entries, including mid-stall.
REQ-031 SHALL give after reset: enq_ready = 1, wb_load = 0, wb_dest = 0, wb_data = 0, hit_a = hit_b = 0, fwd_a = fwd_b = 0.
REQ-032 SHALL ignore enq_valid in a cycle where reset = 1.

Structure
REQ-033 SHALL take lc3b_word and lc3b_reg from lc3b_types; no new package types are needed.
REQ-034 SHALL be one module with no sub-module; entry storage is a register array, not inferred RAM.

Verification
REQ-035 SHALL cover: reset, then enq R3=0x1234 with no stall -> next cycle wb_load=1, wb_dest=3, wb_data=0x1234; count returns to 0 the cycle after.
REQ-036 SHALL cover: wb_stall=1, enq R1=0x0001, R2=0x0002, R3=0x0003, R4=0x0004 -> count=4, enq_ready=0; a 5th offer is dropped; release stall -> writes drain in order over 4 cycles.
REQ-037 SHALL cover: stall held, enq R5=0xAAAA then R5=0xBBBB, lookup_a=5, lookup_b=6 -> hit_a=1, fwd_a=0xBBBB, hit_b=0, fwd_b=0.
REQ-038 SHALL cover: full queue, stall released with enq_valid held -> enq_ready=0 that cycle, accepted the next cycle; count goes 4->3->3.
REQ-039 SHALL cover: 3 entries queued under stall, reset pulsed -> count=0, wb_load=0, hit_a=0 the following cycle.
REQ-040 SHALL cover: 10 back-to-back enq/drain pairs, no stall -> pointers wrap and every write appears once, in order.
